// File: rtl/alu_adder_arbiter.sv
// Round-robin arbiter sharing one external add/sub/inc/dec adder between two requesters.
// Optional grant/error counters are enabled with the ARB_STATS_EN macro.
module alu_adder_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_op1,
   input  logic [WIDTH-1:0] r0_op2,
   input  logic [3:0]       r0_sel,
   output logic             r0_rsp_valid,
   input  logic             r0_rsp_ready,
   output logic [WIDTH-1:0] r0_rsp_data,
   output logic             r0_rsp_err,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_op1,
   input  logic [WIDTH-1:0] r1_op2,
   input  logic [3:0]       r1_sel,
   output logic             r1_rsp_valid,
   input  logic             r1_rsp_ready,
   output logic [WIDTH-1:0] r1_rsp_data,
   output logic             r1_rsp_err,
   output logic [WIDTH-1:0] add_op1,
   output logic [WIDTH-1:0] add_op2,
   output logic [3:0]       add_sel,
   input  logic [WIDTH-1:0] add_result,
   output logic             busy
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_reg, state_next;
   logic             prio_reg, win_reg, err_reg;
   logic [WIDTH-1:0] op1_reg, op2_reg, rsp_data_reg;
   logic [3:0]       sel_reg;

   logic             grant0, grant1, accept, rsp_taken, in_err;
   logic [WIDTH-1:0] in_op1, in_op2;
   logic [3:0]       in_sel;

   always_comb begin
      state_next = state_reg;
      grant0     = 1'b0;
      grant1     = 1'b0;
      rsp_taken  = win_reg ? r1_rsp_ready : r0_rsp_ready;
      case (state_reg)
         IDLE: begin
            if (r0_valid && r1_valid) begin
               grant0 = !prio_reg;
               grant1 = prio_reg;
            end else begin
               grant0 = r0_valid;
               grant1 = r1_valid;
            end
            if (r0_valid || r1_valid) state_next = EXEC;
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_taken) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign accept = grant0 | grant1;
   assign in_op1 = grant1 ? r1_op1 : r0_op1;
   assign in_op2 = grant1 ? r1_op2 : r0_op2;
   assign in_sel = grant1 ? r1_sel : r0_sel;
   // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
   assign in_err = !((in_sel != 4'd0) && ((in_sel & (in_sel - 4'd1)) == 4'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         prio_reg     <= 1'b0;
         win_reg      <= 1'b0;
         err_reg      <= 1'b0;
         op1_reg      <= '0;
         op2_reg      <= '0;
         sel_reg      <= '0;
         rsp_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op1_reg <= in_op1;
            op2_reg <= in_op2;
            sel_reg <= in_sel;
            err_reg <= in_err;
            win_reg <= grant1;
         end
         if (state_reg == EXEC) rsp_data_reg <= add_result;
         if (state_reg == RESP && rsp_taken) prio_reg <= ~win_reg;
      end
   end

   assign r0_ready     = grant0;
   assign r1_ready     = grant1;
   assign busy         = (state_reg != IDLE);
   assign add_op1      = op1_reg;
   assign add_op2      = op2_reg;
   // A bad select reaches the adder as all-zero so the result is forced to 0.
   assign add_sel      = (state_reg == EXEC && !err_reg) ? sel_reg : 4'd0;
   assign r0_rsp_valid = (state_reg == RESP) && !win_reg;
   assign r1_rsp_valid = (state_reg == RESP) && win_reg;
   assign r0_rsp_data  = rsp_data_reg;
   assign r1_rsp_data  = rsp_data_reg;
   assign r0_rsp_err   = r0_rsp_valid & err_reg;
   assign r1_rsp_err   = r1_rsp_valid & err_reg;

`ifdef ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         err_cnt    <= '0;
      end else begin
         if (grant0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_ONE;
         if (grant1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_ONE;
         if (accept && in_err && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = CNT_W[0];
`endif

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Directed bench for alu_adder_arbiter with a behavioural model of the external adder.
// Stats counters are checked only when ARB_STATS_EN is defined.
module tb_alu_adder_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r0_valid = 1'b0, r1_valid = 1'b0;
   logic       r0_ready, r1_ready;
   logic [7:0] r0_op1 = '0, r0_op2 = '0, r1_op1 = '0, r1_op2 = '0;
   logic [3:0] r0_sel = '0, r1_sel = '0;
   logic       r0_rsp_valid, r1_rsp_valid;
   logic       r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
   logic [7:0] r0_rsp_data, r1_rsp_data;
   logic       r0_rsp_err, r1_rsp_err;
   logic [7:0] add_op1, add_op2, add_result;
   logic [3:0] add_sel;
   logic       busy;
`ifdef ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, err_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu_adder_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2),
      .r0_sel(r0_sel), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
      .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2),
      .r1_sel(r1_sel), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
      .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
      .add_op1(add_op1), .add_op2(add_op2), .add_sel(add_sel),
      .add_result(add_result), .busy(busy)
`ifdef ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // External combinational adder; a zero select yields 0.
   always_comb begin
      add_result = 8'h00;
      case (add_sel)
         4'b0001: add_result = add_op1 + add_op2;
         4'b0010: add_result = add_op1 - add_op2;
         4'b0100: add_result = add_op1 + 8'd1;
         4'b1000: add_result = add_op1 - 8'd1;
         default: add_result = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] s);
      if (id == 0) begin
         r0_valid = v; r0_op1 = a; r0_op2 = b; r0_sel = s;
      end else begin
         r1_valid = v; r1_op1 = a; r1_op2 = b; r1_sel = s;
      end
   endtask

   // Lone request from an idle arbiter, checked through EXEC and RESP.
   task automatic run_op(input string tag, input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] s,
                         input logic [3:0] exp_sel, input logic [7:0] exp_data,
                         input logic exp_err);
      set_req(id, 1'b1, a, b, s);
      r0_rsp_ready = 1'b1;
      r1_rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_ready"}, (id == 0) ? r0_ready : r1_ready, 1'b1);
      tick;
      set_req(id, 1'b0, a, b, s);
      @(negedge clk);
      chk({tag, "_exec_sel"}, add_sel, exp_sel);
      chk({tag, "_exec_busy"}, busy, 1'b1);
      tick;
      @(negedge clk);
      chk({tag, "_rsp_valid"}, (id == 0) ? r0_rsp_valid : r1_rsp_valid, 1'b1);
      chk({tag, "_other_valid"}, (id == 0) ? r1_rsp_valid : r0_rsp_valid, 1'b0);
      chk({tag, "_data"}, (id == 0) ? r0_rsp_data : r1_rsp_data, exp_data);
      chk({tag, "_err"}, (id == 0) ? r0_rsp_err : r1_rsp_err, exp_err);
      $display("op %s: requester %0d data=%0h err=%0b", tag, id,
               (id == 0) ? r0_rsp_data : r1_rsp_data, (id == 0) ? r0_rsp_err : r1_rsp_err);
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_r0_ready", r0_ready, 1'b0);
      chk("rst_r0_rsp_valid", r0_rsp_valid, 1'b0);
      chk("rst_r1_rsp_valid", r1_rsp_valid, 1'b0);
      chk("rst_rsp_data", r0_rsp_data, 8'h00);
      chk("rst_add_op1", add_op1, 8'h00);
      chk("rst_add_sel", add_sel, 4'h0);
      tick;
      rst_n = 1'b1;
      tick;

      // Single add on r0
      run_op("add", 0, 8'h12, 8'h34, 4'b0001, 4'b0001, 8'h46, 1'b0);
      @(negedge clk);
      chk("add_idle_busy", busy, 1'b0);
      chk("add_idle_sel", add_sel, 4'h0);
      chk("add_hold_op1", add_op1, 8'h12);
      tick;

      // Wrap cases on r1 (each r1 completion returns prio to 0)
      run_op("sub_wrap", 1, 8'h00, 8'h01, 4'b0010, 4'b0010, 8'hFF, 1'b0);
      run_op("inc_wrap", 1, 8'hFF, 8'h00, 4'b0100, 4'b0100, 8'h00, 1'b0);
      run_op("dec_wrap", 1, 8'h00, 8'h00, 4'b1000, 4'b1000, 8'hFF, 1'b0);
      run_op("add_wrap", 1, 8'h80, 8'h80, 4'b0001, 4'b0001, 8'h00, 1'b0);

      // Contention: both valid continuously, grants alternate starting at r0
      set_req(0, 1'b1, 8'h10, 8'h01, 4'b0001);
      set_req(1, 1'b1, 8'h50, 8'h20, 4'b0010);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("cont_r0_ready", r0_ready, (k % 2) == 0);
         chk("cont_r1_ready", r1_ready, (k % 2) == 1);
         tick;
         tick;
         @(negedge clk);
         chk("cont_r0_rsp_valid", r0_rsp_valid, (k % 2) == 0);
         chk("cont_r1_rsp_valid", r1_rsp_valid, (k % 2) == 1);
         chk("cont_data", ((k % 2) == 0) ? r0_rsp_data : r1_rsp_data,
             ((k % 2) == 0) ? 8'h11 : 8'h30);
         $display("contention op %0d: r0_rsp_valid=%0b r1_rsp_valid=%0b data=%0h",
                  k, r0_rsp_valid, r1_rsp_valid, r0_rsp_data);
         tick;
      end
      set_req(0, 1'b0, 8'h00, 8'h00, 4'b0000);
      set_req(1, 1'b0, 8'h00, 8'h00, 4'b0000);

      // Backpressure on r0 while r1 keeps requesting
      set_req(0, 1'b1, 8'h12, 8'h34, 4'b0001);
      set_req(1, 1'b1, 8'h01, 8'h02, 4'b0001);
      r0_rsp_ready = 1'b0;
      r1_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_r0_ready", r0_ready, 1'b1);
      chk("bp_r1_ready", r1_ready, 1'b0);
      tick;
      r0_valid = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", r0_rsp_valid, 1'b1);
         chk("bp_rsp_data", r0_rsp_data, 8'h46);
         chk("bp_busy", busy, 1'b1);
         chk("bp_r1_ready", r1_ready, 1'b0);
         tick;
      end
      r0_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_still_valid", r0_rsp_valid, 1'b1);
      tick;
      @(negedge clk);
      chk("bp_r1_granted", r1_ready, 1'b1);
      chk("bp_r0_released", r0_rsp_valid, 1'b0);
      tick;
      r1_valid = 1'b0;
      tick;
      @(negedge clk);
      chk("bp_r1_rsp_valid", r1_rsp_valid, 1'b1);
      chk("bp_r1_data", r1_rsp_data, 8'h03);
      $display("backpressure: r1 data=%0h", r1_rsp_data);
      tick;

      // Bad select after a fresh reset
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      run_op("bad_sel", 1, 8'h11, 8'h22, 4'b0110, 4'b0000, 8'h00, 1'b1);
`ifdef ARB_STATS_EN
      chk("stats_err_cnt", err_cnt, 16'd1);
      chk("stats_grant_cnt1", grant_cnt1, 16'd1);
      chk("stats_grant_cnt0", grant_cnt0, 16'd0);
`endif

      // Reset while in EXEC
      set_req(0, 1'b1, 8'h12, 8'h34, 4'b0001);
      r0_rsp_ready = 1'b1;
      @(negedge clk);
      chk("rexec_ready", r0_ready, 1'b1);
      tick;
      r0_valid = 1'b0;
      @(negedge clk);
      chk("rexec_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rexec_busy_clr", busy, 1'b0);
      chk("rexec_add_op1", add_op1, 8'h00);
      chk("rexec_add_op2", add_op2, 8'h00);
      chk("rexec_add_sel", add_sel, 4'h0);
      chk("rexec_rsp_data", r0_rsp_data, 8'h00);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rexec_no_rsp0", r0_rsp_valid, 1'b0);
         chk("rexec_no_rsp1", r1_rsp_valid, 1'b0);
         tick;
      end
      set_req(0, 1'b1, 8'h12, 8'h34, 4'b0001);
      set_req(1, 1'b1, 8'h01, 8'h02, 4'b0001);
      @(negedge clk);
      chk("rexec_prio_r0", r0_ready, 1'b1);
      chk("rexec_prio_r1", r1_ready, 1'b0);
      tick;
      set_req(0, 1'b0, 8'h00, 8'h00, 4'b0000);
      set_req(1, 1'b0, 8'h00, 8'h00, 4'b0000);
      tick;
      @(negedge clk);
      chk("rexec_final_data", r0_rsp_data, 8'h46);
      chk("rexec_final_valid", r0_rsp_valid, 1'b1);
      $display("reset-in-exec recovery: r0 data=%0h", r0_rsp_data);
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
